// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin grant controller.
package wrr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEFAULT_WEIGHT = 1;

  // Advance an index by one, wrapping back to 0 at n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wrr_grant_ctrl_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    int pos;
    pos    = 0;
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      if (!hit && request[pos]) begin
        hit         = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/wrr_grant_ctrl.sv
// Weighted round-robin grant controller with done-counted credit per grant.
// Optional watchdog enabled by defining WRR_TIMEOUT_EN.
module wrr_grant_ctrl
  import wrr_pkg::*;
#(
  parameter int N   = 4,
  parameter int CW  = 4,
  parameter int TMO = 16,
  parameter int IW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  request,
  input  logic          done,
  input  logic          weight_wr,
  input  logic [IW-1:0] weight_idx,
  input  logic [CW-1:0] weight_data,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id,
  output logic          timeout
);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [CW-1:0]   weight_q [N];
  logic            timeout_q, timeout_d;

  logic            pick_hit;
  logic [N-1:0]    pick_onehot;
  logic [IW-1:0]   pick_idx;

`ifdef WRR_TIMEOUT_EN
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TW-1:0]   timer_q, timer_d;
`endif

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .request (request),
    .ptr     (ptr_q),
    .hit     (pick_hit),
    .onehot  (pick_onehot),
    .idx     (pick_idx)
  );

  // Weight table; a zero weight is stored as one so credit never starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) weight_q[i] <= CW'(DEFAULT_WEIGHT);
    end else if (weight_wr && (int'(weight_idx) < N)) begin
      weight_q[weight_idx] <= (weight_data == '0) ? CW'(DEFAULT_WEIGHT) : weight_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      grant_q   <= '0;
      credit_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      grant_q   <= grant_d;
      credit_q  <= credit_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef WRR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    grant_d   = grant_q;
    credit_d  = credit_q;
    timeout_d = 1'b0;
`ifdef WRR_TIMEOUT_EN
    timer_d   = timer_q;
`endif

    case (state_q)
      BUSY: begin
        // Release ordering: owner drop, last credit, then watchdog.
        if (!request[gid_q] || (done && credit_q == CW'(1))) begin
          state_d = GAP;
          grant_d = '0;
          gid_d   = '0;
          ptr_d   = IW'(next_idx(32'(gid_q), N));
        end else if (done) begin
          credit_d = credit_q - CW'(1);
`ifdef WRR_TIMEOUT_EN
          timer_d  = '0;
        end else if (timer_q == TW'(TMO - 1)) begin
          state_d   = GAP;
          grant_d   = '0;
          gid_d     = '0;
          ptr_d     = IW'(next_idx(32'(gid_q), N));
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
`endif
        end
      end
      default: begin
        if (pick_hit) begin
          state_d  = BUSY;
          grant_d  = pick_onehot;
          gid_d    = pick_idx;
          credit_d = weight_q[pick_idx];
`ifdef WRR_TIMEOUT_EN
          timer_d  = '0;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
          gid_d   = '0;
        end
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_wrr_grant_ctrl.sv
// Directed self-checking bench for wrr_grant_ctrl (N=4, CW=4, TMO=16).
module tb_wrr_grant_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] request;
  logic       done;
  logic       weight_wr;
  logic [1:0] weight_idx;
  logic [3:0] weight_data;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  wrr_grant_ctrl #(.N(4), .CW(4), .TMO(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .done        (done),
    .weight_wr   (weight_wr),
    .weight_idx  (weight_idx),
    .weight_data (weight_data),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; request = '0; done = 1'b0; weight_wr = 1'b0;
    step;
    rst = 1'b0;
  endtask

  task automatic write_weight(input logic [1:0] idx, input logic [3:0] w);
    weight_wr = 1'b1; weight_idx = idx; weight_data = w;
    step;
    weight_wr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; request = 4'b1111; done = 1'b0; weight_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if ({grant, grant_valid, timeout, grant_id} !== 8'b0) begin
        errors++;
        $display("[TB] FAIL reset cyc%0d: grant=%b valid=%b tmo=%b id=%0d expected all zero",
                 i, grant, grant_valid, timeout, grant_id);
      end
    end
    rst = 1'b0;
    step;
    checks++;
    if ({grant, grant_valid, grant_id} !== {4'b0001, 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL first_grant: grant=%b valid=%b id=%0d expected 0001 1 0",
               grant, grant_valid, grant_id);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] expGrant [9];
    logic [1:0] expId [9];
    expGrant = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    expId    = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    do_reset;
    request = 4'b1111; done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step;
      checks++;
      if ({grant, grant_valid, grant_id} !== {expGrant[i], |expGrant[i], expId[i]}) begin
        errors++;
        $display("[TB] FAIL rr step%0d: grant=%b valid=%b id=%0d expected %b %b %0d",
                 i, grant, grant_valid, grant_id, expGrant[i], |expGrant[i], expId[i]);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_weighting;
    logic [3:0] expGrant [6];
    do_reset;
    write_weight(2'd2, 4'd3);
    // Grant requester 1, then drop it so the pointer lands on 2.
    request = 4'b0010;
    step;
    request = 4'b0101;
    step;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL weight_setup: grant=%b expected 0000", grant);
    end
    expGrant = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      done = (i >= 1 && i <= 3) || (i == 5);
      step;
      checks++;
      if (grant !== expGrant[i]) begin
        errors++;
        $display("[TB] FAIL weight step%0d: grant=%b expected %b", i, grant, expGrant[i]);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_weight_edges;
    // A zero weight behaves as one.
    do_reset;
    write_weight(2'd3, 4'd0);
    request = 4'b1000;
    step;
    done = 1'b1;
    step;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL weight_zero: grant=%b expected 0000", grant);
    end
    // A write coinciding with the grant load loads the old weight.
    do_reset;
    request = 4'b0001; done = 1'b0;
    weight_wr = 1'b1; weight_idx = 2'd0; weight_data = 4'd3;
    step;
    weight_wr = 1'b0; done = 1'b1;
    step;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL weight_same_edge: grant=%b expected 0000", grant);
    end
    done = 1'b0;
    step;
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (grant !== ((i < 2) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL weight_new step%0d: grant=%b expected %b",
                 i, grant, (i < 2) ? 4'b0001 : 4'b0000);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_watchdog;
    do_reset;
    request = 4'b0010; done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step;
      checks++;
      if ({grant, timeout} !== {4'b0010, 1'b0}) begin
        errors++;
        $display("[TB] FAIL watchdog_hold cyc%0d: grant=%b tmo=%b expected 0010 0", i, grant, timeout);
      end
    end
`ifdef WRR_TIMEOUT_EN
    step;
    checks++;
    if ({grant, grant_valid, timeout} !== {4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL watchdog_fire: grant=%b valid=%b tmo=%b expected 0000 0 1",
               grant, grant_valid, timeout);
    end
    step;
    checks++;
    if ({grant, timeout} !== {4'b0010, 1'b0}) begin
      errors++;
      $display("[TB] FAIL watchdog_regrant: grant=%b tmo=%b expected 0010 0", grant, timeout);
    end
`else
    for (int i = 0; i < 4; i++) begin
      step;
      checks++;
      if ({grant, timeout} !== {4'b0010, 1'b0}) begin
        errors++;
        $display("[TB] FAIL no_watchdog cyc%0d: grant=%b tmo=%b expected 0010 0", i, grant, timeout);
      end
    end
`endif
    request = 4'b0000;
  endtask

  task automatic test_request_drop;
    do_reset;
    request = 4'b0100; done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (grant !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL drop_hold cyc%0d: grant=%b expected 0100", i, grant);
      end
    end
    request = 4'b1001;
    step;
    checks++;
    if ({grant, timeout} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL drop_release: grant=%b tmo=%b expected 0000 0", grant, timeout);
    end
    step;
    checks++;
    if ({grant, grant_id} !== {4'b1000, 2'd3}) begin
      errors++;
      $display("[TB] FAIL drop_next: grant=%b id=%0d expected 1000 3", grant, grant_id);
    end
    request = 4'b0000;
  endtask

  task automatic test_reset_mid_busy;
    do_reset;
    write_weight(2'd3, 4'd3);
    request = 4'b1000; done = 1'b0;
    step;
    done = 1'b1;
    step;
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL midbusy_hold: grant=%b expected 1000", grant);
    end
    done = 1'b0; rst = 1'b1;
    step;
    checks++;
    if ({grant, grant_valid, grant_id, timeout} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL midbusy_reset: grant=%b valid=%b id=%0d tmo=%b expected all zero",
               grant, grant_valid, grant_id, timeout);
    end
    rst = 1'b0; request = 4'b1001;
    step;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midbusy_ptr: grant=%b expected 0001", grant);
    end
    // Weight of requester 3 is back to one after reset.
    done = 1'b1;
    step;
    step;
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL midbusy_owner3: grant=%b expected 1000", grant);
    end
    step;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midbusy_weight: grant=%b expected 0000", grant);
    end
    done = 1'b0; request = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; request = '0; done = 1'b0;
    weight_wr = 1'b0; weight_idx = '0; weight_data = '0;
    test_reset;
    test_round_robin;
    test_weighting;
    test_weight_edges;
    test_watchdog;
    test_request_drop;
    test_reset_mid_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
